line_feeder: RTL and testbench

LINE_FEEDER -- requirements
Module: line_feeder

---
 rtl/line_feeder_if.sv | 28 ++
 rtl/line_feeder.sv | 110 +++++++++++
 tb/tb_line_feeder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_feeder_if.sv
// line_feeder_if -- pixel-in / column-out stream bundle for line_feeder.
// master: upstream/downstream environment side; slave: the line_feeder block.
interface line_feeder_if #(
  parameter int IMG_W = 8
) ();
  localparam int COL_W = $clog2(IMG_W);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       data1;
  logic [7:0]       data2;
  logic [7:0]       data3;
  logic [COL_W-1:0] out_col;
  logic             frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, data1, data2, data3, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, data1, data2, data3, out_col, frame_done
  );
endinterface

// File: rtl/line_feeder.sv
// line_feeder -- turns a raster pixel stream into vertical 3-tap columns
// (rows r-2, r-1, r) using two line buffers, with a one-deep output register.
// Optional feature: define LINE_FEEDER_ZERO_PAD_EN to also emit columns for
// rows 0 and 1 with the missing taps forced to zero.
module line_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic         clk,
  input logic         rst_n,
  line_feeder_if.slave bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [7:0]       lb_old [IMG_W];
  logic [7:0]       lb_mid [IMG_W];

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             out_valid_q;
  logic [7:0]       d1_q, d2_q, d3_q;
  logic [COL_W-1:0] out_col_q;
  logic             frame_done_q;

  logic             in_ready_c;
  logic             hs_in;
  logic             emit;
  logic             col_last;
  logic             row_last;
  logic [7:0]       tap_old;
  logic [7:0]       tap_mid;

  // Handshake, wrap detection and tap selection for the pixel at (row_q, col_q)
  always_comb begin
    in_ready_c = !out_valid_q || bus.out_ready;
    hs_in      = bus.in_valid && in_ready_c;
    col_last   = (col_q == COL_W'(IMG_W - 1));
    row_last   = (row_q == ROW_W'(IMG_H - 1));
`ifdef LINE_FEEDER_ZERO_PAD_EN
    emit       = hs_in;
    tap_old    = (row_q < ROW_W'(2)) ? '0 : lb_old[col_q];
    tap_mid    = (row_q == '0)       ? '0 : lb_mid[col_q];
`else
    emit       = hs_in && (row_q >= ROW_W'(2));
    tap_old    = lb_old[col_q];
    tap_mid    = lb_mid[col_q];
`endif
  end

  // Raster position counters: column advances per pixel, row on column wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (hs_in) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Line buffers shift vertically at the current column; contents need no reset
  always_ff @(posedge clk) begin
    if (hs_in) begin
      lb_old[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= bus.in_data;
    end
  end

  // Output register: load on emit (no bubble), drop after downstream accept, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      out_col_q   <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      d1_q        <= tap_old;
      d2_q        <= tap_mid;
      d3_q        <= bus.in_data;
      out_col_q   <= col_q;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle end-of-frame pulse after the last pixel is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= hs_in && col_last && row_last;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.data1      = d1_q;
  assign bus.data2      = d2_q;
  assign bus.data3      = d3_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_line_feeder.sv
// tb_line_feeder -- directed checks of line_feeder at IMG_W=4, IMG_H=4.
// Column words are packed {data1, data2, data3, out_col}.
module tb_line_feeder;
  localparam int W = 4;
  localparam int H = 4;
`ifdef LINE_FEEDER_ZERO_PAD_EN
  localparam int NCOL = W * H;
  localparam logic [31:0] FIRST_COL = {8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [31:0] F2_FIRST  = {8'd0, 8'd0, 8'd100, 8'd0};
`else
  localparam int NCOL = (H - 2) * W;
  localparam logic [31:0] FIRST_COL = {8'd0, 8'd4, 8'd8, 8'd0};
  localparam logic [31:0] F2_FIRST  = {8'd100, 8'd104, 8'd108, 8'd0};
`endif
  localparam logic [31:0] LAST_COL = {8'd7, 8'd11, 8'd15, 8'd3};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  line_feeder_if #(.IMG_W(W)) bus ();

  line_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = -1;
  int hs_cyc_last = -2;
  bit rand_rdy = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record column handshakes (completing at the next rising edge) and frame_done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready)
        obs_q.push_back({bus.data1, bus.data2, bus.data3, 8'(bus.out_col)});
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  // Random downstream back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_col(input int base, input int k);
    int r, c;
    logic [7:0] d1, d2, d3;
`ifdef LINE_FEEDER_ZERO_PAD_EN
    r = k / W;
`else
    r = k / W + 2;
`endif
    c  = k % W;
    d3 = 8'(base + r * W + c);
    d2 = (r >= 1) ? 8'(base + (r - 1) * W + c) : 8'd0;
    d1 = (r >= 2) ? 8'(base + (r - 2) * W + c) : 8'd0;
    return {d1, d2, d3, 8'(c)};
  endfunction

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic push_frame(input int base);
    for (int k = 0; k < NCOL; k++) exp_q.push_back(ref_col(base, k));
  endtask

  task automatic compare(input string tag);
    chk({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s col%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel and wait (bounded) for it to be accepted
  task automatic send_pixel(input logic [7:0] v);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    hs_cyc_last  = cyc;
    bus.in_valid = 1'b0;
    if (!done) chk("in_ready timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      send_pixel(8'(base + i));
    end
  endtask

  task automatic do_reset(input bit check_state);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    if (check_state) begin
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst frame_done", 32'(bus.frame_done), 32'd0);
      chk("rst data", {bus.data1, bus.data2, bus.data3, 8'(bus.out_col)}, 32'd0);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
    fd_cnt = 0;
    fd_cyc = -1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Single frame, free-flowing output
    do_reset(1'b1);
    push_frame(0);
    send_frame(0, 1'b0);
    drain(5);
    compare("t1");
    chk("t1 first", obs_at(0), FIRST_COL);
    chk("t1 last", obs_at(NCOL - 1), LAST_COL);
    chk("t1 fd count", 32'(fd_cnt), 32'd1);
    chk("t1 fd cycle", 32'(fd_cyc), 32'(hs_cyc_last));

    // Downstream stall on the first column
    do_reset(1'b0);
    bus.out_ready = 1'b0;
    push_frame(0);
    fork
      send_frame(0, 1'b0);
      begin
        for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
        chk("t2 valid seen", 32'(bus.out_valid), 32'd1);
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          chk("t2 hold", {bus.data1, bus.data2, bus.data3, 8'(bus.out_col)}, exp_q[0]);
          chk("t2 in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain(5);
    compare("t2");

    // Two frames back to back
    do_reset(1'b0);
    push_frame(0);
    push_frame(100);
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain(5);
    compare("t3");
    chk("t3 f2 first", obs_at(NCOL), F2_FIRST);
    chk("t3 fd count", 32'(fd_cnt), 32'd2);

    // Reset mid-frame, then a fresh frame
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) send_pixel(8'(i));
    do_reset(1'b1);
    push_frame(0);
    send_frame(0, 1'b0);
    drain(5);
    compare("t4");
    chk("t4 first", obs_at(0), FIRST_COL);

    // Random input gaps and back-pressure over three frames
    do_reset(1'b0);
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(0);
    for (int f = 0; f < 3; f++) send_frame(0, 1'b1);
    drain(10);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain(5);
    compare("t5");
    chk("t5 fd count", 32'(fd_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
